// File: rtl/operand_fetch.sv
// operand_fetch: fetches one or two register operands through a shared read port and holds them coherent until execute takes them
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_src_a,
  input  logic [ADDR_W-1:0] req_src_b,
  input  logic              req_need_b,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b
);
  typedef enum logic [1:0] {IDLE, READ_A, READ_B, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d;
  logic need_b_q, need_b_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DATA_W-1:0] fwd;
  logic hit_a, hit_b;
  assign hit_a = wr_en && (wr_addr == src_a_q);
  assign hit_b = wr_en && (wr_addr == src_b_q);
  assign fwd = (wr_en && (wr_addr == rd_addr)) ? wr_data : rd_data;
  assign op_a = op_a_q;
  assign op_b = op_b_q;
  // next state, read address, operand capture and write snooping
  always_comb begin
    state_d   = state_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    need_b_d  = need_b_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    req_ready = (state_q == IDLE);
    out_valid = (state_q == HOLD);
    rd_addr   = (state_q == READ_A) ? src_a_q : (state_q == READ_B) ? src_b_q : '0;
    case (state_q)
      IDLE: if (req_valid) begin
        src_a_d  = req_src_a;
        src_b_d  = req_src_b;
        need_b_d = req_need_b;
        op_b_d   = '0;
        state_d  = READ_A;
      end
      READ_A: begin
        op_a_d  = fwd;
        state_d = need_b_q ? READ_B : HOLD;
      end
      READ_B: begin
        op_b_d  = fwd;
        op_a_d  = hit_a ? wr_data : op_a_q;
        state_d = HOLD;
      end
      HOLD: if (out_ready) state_d = IDLE;
      else begin
        op_a_d = hit_a ? wr_data : op_a_q;
        op_b_d = (need_b_q && hit_b) ? wr_data : op_b_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and operand registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      src_a_q  <= '0;
      src_b_q  <= '0;
      need_b_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      need_b_q <= need_b_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
    end
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Read-side companion to the 16-bit R0–R7 register bank: accepts a decoded operand request (one or two source register indices) over a valid/ready handshake, reads the bank through its single shared read port one register per cycle, and presents both operands to the ALU stage over a second valid/ready handshake. Write-port traffic is snooped so that fetched and held operands always reflect the most recent committed value. Sits between the decoder and the ALU/execute stage.

## Interface

- DATA_W, 16, operand and register width
- ADDR_W, 3, register index width (8 registers)

- clk  in  1  clock, all state updates on rising edge
- rst_b  in  1  reset, asynchronous, active-low
- req_valid  in  1  decoder presents a request
- req_ready  out  1  block can accept a request
- req_src_a  in  ADDR_W  first source register index
- req_src_b  in  ADDR_W  second source register index
- req_need_b  in  1  1 = two-operand request, 0 = op_b unused
- rd_addr  out  ADDR_W  register bank read address
- rd_data  in  DATA_W  register bank read data, combinational from rd_addr
- wr_en  in  1  register bank write enable (same cycle as bank write)
- wr_addr  in  ADDR_W  register bank write index
- wr_data  in  DATA_W  register bank write data
- out_valid  out  1  op_a/op_b valid
- out_ready  in  1  execute stage accepts operands
- op_a  out  DATA_W  first operand
- op_b  out  DATA_W  second operand (0 when need_b = 0)

## Operation

- States: IDLE, READ_A, READ_B, HOLD. Encoding free.
- IDLE: req_ready = 1. On req_valid: latch src_a, src_b, need_b; clear op_b to 0; go READ_A.
- READ_A: rd_addr = src_a; capture op_a = fwd(src_a). Next READ_B if need_b, else HOLD.
- READ_B: rd_addr = src_b; capture op_b = fwd(src_b); go HOLD.
- HOLD: out_valid = 1. On out_ready: go IDLE.
- fwd(x) = wr_data if wr_en and wr_addr == x, else rd_data. Same-cycle write always wins over bank data.
- Coherence snoop: in READ_B and HOLD, if wr_en and wr_addr == src_a, op_a <= wr_data. In HOLD with need_b = 1, if wr_en and wr_addr == src_b, op_b <= wr_data. src_a == src_b: both updated.
- req_ready = 1 only in IDLE; out_valid = 1 only in HOLD; never both.
- rd_addr = src_a in READ_A, src_b in READ_B, 0 otherwise.
- Requests while not IDLE are ignored (not latched).

## Timing

- Reset (async, rst_b low): state IDLE, op_a = 0, op_b = 0, out_valid = 0, req_ready = 1, rd_addr = 0, latched indices 0. Reset mid-fetch aborts the fetch; no out_valid follows.
- Accept at edge T (IDLE, req_valid high): READ_A during cycle T+1; two-operand: READ_B in T+2, out_valid high from T+3; one-operand: out_valid high from T+2.
- out_valid held until out_ready sampled high; transfer completes at that edge; IDLE (req_ready = 1) next cycle. Minimum spacing between accepts: 4 cycles (two-operand), 3 (one-operand).
- op_a/op_b may change while out_valid is high only via the coherence snoop; otherwise stable.
- Snoop write in the same cycle as the out_ready handshake: operand value transferred is the pre-write value; update is discarded (state leaves HOLD).

## Test plan

- Reset: drive rst_b low mid-READ_B -> immediately IDLE, req_ready = 1, out_valid = 0, op_a = op_b = 0; no later out_valid.
- Two-operand fetch: bank R2 = 0x1234, R5 = 0xBEEF, request src_a = 2, src_b = 5, need_b = 1 at T, out_ready = 1 -> rd_addr = 2 at T+1, 5 at T+2, out_valid at T+3 with op_a = 0x1234, op_b = 0xBEEF, IDLE at T+4.
- One-operand fetch: src_a = 7 (0x00FF), need_b = 0 -> out_valid at T+2, op_a = 0x00FF, op_b = 0x0000.
- Same-cycle forward: in READ_A, wr_en = 1, wr_addr = src_a = 3, wr_data = 0xA5A5, bank returns stale 0x0001 -> op_a = 0xA5A5.
- Backpressure + snoop: out_ready = 0 for 5 cycles in HOLD (src_a = 1, src_b = 1), write R1 = 0x7777 during HOLD -> op_a = op_b = 0x7777 next cycle, out_valid stays 1; out_ready = 1 -> single transfer, then IDLE.
- Ignored request: assert req_valid with src_a = 6 while in READ_B -> not latched; current transfer completes unchanged; new request accepted only after returning to IDLE.
